// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads imem, loads the IF/ID register.
// Optional J pre-decode in fetch when IF_EARLY_JUMP_EN is defined.
package if_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;
endpackage

module if_fetch_stage
  import if_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_inst,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [31:0]       fetch_count
);

  logic [31:0] pcQ;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4;
  logic [31:0] countQ;
  if_id_t      ifidQ;
  if_id_t      ifidNext;
  logic        loadValid;

  assign pcPlus4   = pcQ + 32'd4;
  assign imem_addr = pcQ[ADDR_W+1:2];
  assign loadValid = !flush && !stall;

`ifdef IF_EARLY_JUMP_EN
  logic        isJump;
  logic [31:0] jumpPc;

  assign isJump = (imem_rdata[31:26] == 6'b000010);
  assign jumpPc = {pcPlus4[31:28], imem_rdata[25:0], 2'b00};
`endif

  // Redirect outranks stall; the early jump only fires on a clean load.
  always_comb begin
    pcNext = pcPlus4;
    if (redirect_valid) begin
      pcNext = redirect_pc & 32'hFFFF_FFFC;
    end else if (stall) begin
      pcNext = pcQ;
`ifdef IF_EARLY_JUMP_EN
    end else if (!flush && isJump) begin
      pcNext = jumpPc;
`endif
    end
  end

  always_comb begin
    ifidNext = ifidQ;
    if (flush) begin
      ifidNext = '0;
    end else if (!stall) begin
      ifidNext.inst  = imem_rdata;
      ifidNext.pc4   = pcPlus4;
      ifidNext.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcQ    <= RESET_PC;
      ifidQ  <= '0;
      countQ <= '0;
    end else begin
      pcQ   <= pcNext;
      ifidQ <= ifidNext;
      if (loadValid) begin
        countQ <= countQ + 32'd1;
      end
    end
  end

  assign pc          = pcQ;
  assign ifid_inst   = ifidQ.inst;
  assign ifid_pc4    = ifidQ.pc4;
  assign ifid_valid  = ifidQ.valid;
  assign fetch_count = countQ;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, async reset case,
// then randomized traffic against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam int ADDR_W = 16;

`ifdef IF_EARLY_JUMP_EN
  localparam bit EJ = 1'b1;
`else
  localparam bit EJ = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       pc;
  logic [31:0]       ifid_inst;
  logic [31:0]       ifid_pc4;
  logic              ifid_valid;
  logic [31:0]       fetch_count;

  logic [31:0] mem [0:65535];

  int nVec;
  int nErr;

  if_fetch_stage #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .ifid_inst     (ifid_inst),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fl;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] ePc;
    logic [31:0] eInst;
    logic [31:0] ePc4;
    logic        eValid;
    logic [31:0] eCnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic st, logic fl, logic rv,
                              logic [31:0] rpc, logic [31:0] ePc,
                              logic [31:0] eInst, logic [31:0] ePc4,
                              logic eValid, logic [31:0] eCnt);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.ePc = ePc; v.eInst = eInst; v.ePc4 = ePc4;
    v.eValid = eValid; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string tag, input logic [31:0] ePc,
                        input logic [31:0] eInst, input logic [31:0] ePc4,
                        input logic eValid, input logic [31:0] eCnt);
    logic [31:0] eAddr;
    eAddr = {16'h0, ePc[17:2]};
    chk({tag, ".pc"}, pc, ePc);
    chk({tag, ".imem_addr"}, {16'h0, imem_addr}, eAddr);
    chk({tag, ".inst"}, ifid_inst, eInst);
    chk({tag, ".pc4"}, ifid_pc4, ePc4);
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, eValid});
    chk({tag, ".count"}, fetch_count, eCnt);
  endtask

  // Behavioural model state
  logic [31:0] mPc, mInst, mPc4, mCnt;
  logic        mValid;

  task automatic modelEdge(input logic st, input logic fl, input logic rv,
                           input logic [31:0] rpc);
    logic [31:0] cur;
    logic [31:0] seq;
    logic [31:0] nPc;
    cur = mem[mPc[17:2]];
    seq = mPc + 32'd4;
    if (rv)
      nPc = {rpc[31:2], 2'b00};
    else if (st)
      nPc = mPc;
    else if (EJ && !fl && cur[31:26] == 6'b000010)
      nPc = {seq[31:28], cur[25:0], 2'b00};
    else
      nPc = seq;
    if (fl) begin
      mInst = 0; mPc4 = 0; mValid = 0;
    end else if (!st) begin
      mInst = cur; mPc4 = seq; mValid = 1; mCnt = mCnt + 1;
    end
    mPc = nPc;
  endtask

  initial begin
    logic [31:0] jPc;
    nVec = 0;
    nErr = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0]  = 32'h0020_1820;
    mem[3]  = 32'h0000_0000;
    mem[14] = 32'h0800_0000;

    jPc = EJ ? 32'h0 : 32'h3c;
    tbl[0]  = mk(0,0,0,0,         32'h04, 32'h00201820, 32'h04, 1, 1);
    tbl[1]  = mk(0,0,0,0,         32'h08, 32'h20000001, 32'h08, 1, 2);
    tbl[2]  = mk(1,0,0,0,         32'h08, 32'h20000001, 32'h08, 1, 2);
    tbl[3]  = mk(1,0,0,0,         32'h08, 32'h20000001, 32'h08, 1, 2);
    tbl[4]  = mk(0,0,0,0,         32'h0c, 32'h20000002, 32'h0c, 1, 3);
    tbl[5]  = mk(0,0,0,0,         32'h10, 32'h00000000, 32'h10, 1, 4);
    tbl[6]  = mk(0,0,0,0,         32'h14, 32'h20000004, 32'h14, 1, 5);
    tbl[7]  = mk(0,1,1,32'h33,    32'h30, 32'h0, 32'h0, 0, 5);
    tbl[8]  = mk(0,0,0,0,         32'h34, 32'h2000000c, 32'h34, 1, 6);
    tbl[9]  = mk(1,1,0,0,         32'h34, 32'h0, 32'h0, 0, 6);
    tbl[10] = mk(0,0,0,0,         32'h38, 32'h2000000d, 32'h38, 1, 7);
    tbl[11] = mk(0,0,0,0,         jPc,    32'h08000000, 32'h3c, 1, 8);
    tbl[12] = mk(1,0,1,32'h100,   32'h100, 32'h08000000, 32'h3c, 1, 8);
    tbl[13] = mk(0,0,0,0,         32'h104, 32'h20000040, 32'h104, 1, 9);
    tbl[14] = mk(0,1,1,32'hffffffff, 32'hfffffffc, 32'h0, 32'h0, 0, 9);
    tbl[15] = mk(0,0,0,0,         32'h0, 32'h2000ffff, 32'h0, 1, 10);

    rst = 1'b0;
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    #84;
    chkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].st;
      flush = tbl[i].fl;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chkAll($sformatf("vec%0d", i), tbl[i].ePc, tbl[i].eInst,
             tbl[i].ePc4, tbl[i].eValid, tbl[i].eCnt);
    end

    // Async reset while stalled: no clock edge needed
    stall = 1; flush = 0; redirect_valid = 0;
    @(posedge clk);
    #1;
    chkAll("prestall", 32'h0, 32'h2000ffff, 32'h0, 1'b1, 32'd10);
    #2 rst = 1'b0;
    #1;
    chkAll("asyncrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    stall = 0;

    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 5) == 0)
        mem[i] = {6'b000010, 26'($urandom_range(0, 255))};
      else
        mem[i] = $urandom;
    end
    mPc = 0; mInst = 0; mPc4 = 0; mValid = 0; mCnt = 0;

    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom
                                                : 32'($urandom_range(0, 1023));
      modelEdge(stall, flush, redirect_valid, redirect_pc);
      @(posedge clk);
      #1;
      chkAll($sformatf("rnd%0d", i), mPc, mInst, mPc4, mValid, mCnt);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Sits directly upstream of the decode stage.
- Owns the program counter and drives the word-addressed instruction-memory read port.
- Registers the fetched instruction and PC+4 into the IF/ID pipeline register.
- Accepts stall requests from hazard detection, and flush/redirect requests from branch/jump resolution in later stages.

Parameters:
- ADDR_W, 16, instruction-memory word-address width (65536 words)
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  replace the next IF/ID contents with a bubble
- redirect_valid  in  1  load redirect_pc into PC at next edge
- redirect_pc  in  32  redirect target, byte address
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2]; combinational from PC
- imem_rdata  in  32  instruction word; combinational read of imem_addr
- pc  out  32  current fetch PC
- ifid_inst  out  32  registered instruction for decode
- ifid_pc4  out  32  registered PC+4 of that instruction
- ifid_valid  out  1  1 = ifid_inst is a real fetched instruction
- fetch_count  out  32  number of valid instructions delivered to IF/ID

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC
  - ifid_inst=0, ifid_pc4=0, ifid_valid=0, fetch_count=0
  - Takes effect immediately, including mid-stall or mid-redirect.
- Reset release: the first rising edge with rst=1 latches mem[RESET_PC>>2] into IF/ID, with ifid_valid=1. Fetch latency is one cycle.
- Per-edge priority (highest first):
  1. redirect_valid=1 -> pc <= {redirect_pc[31:2],2'b00}; low two bits are forced to zero.
  2. stall=1 -> pc holds.
  3. otherwise -> pc <= pc+4. Wraps modulo 2^32; imem_addr wraps modulo 2^ADDR_W.
- IF/ID update, same edge:
  - flush=1 -> ifid_inst=0 (NOP), ifid_pc4=0, ifid_valid=0. Overrides stall.
  - else stall=1 -> IF/ID holds all fields.
  - else -> ifid_inst=imem_rdata, ifid_pc4=pc+4, ifid_valid=1.
- redirect_valid with stall=1: the redirect still loads the PC; IF/ID obeys the flush/stall rules independently. The controller normally asserts flush together with redirect.
- fetch_count increments by 1 on every edge where IF/ID loads with ifid_valid=1. It wraps at 2^32 and does not increment on stall or flush.
- An all-zero instruction fetched from memory is a legal NOP: it is delivered with ifid_valid=1 and counted.
- Outputs are glitch-free registers except imem_addr, which is combinational from pc.

Optional Feature:
- Macro: IF_EARLY_JUMP_EN.
- Defined:
  - Fetch pre-decodes imem_rdata[31:26]==6'b000010 (J).
  - When not redirecting, not stalling and not flushing, next pc <= {pc_plus4[31:28], imem_rdata[25:0], 2'b00}.
  - The J word itself still enters IF/ID with valid=1, so there is no fetch penalty.
  - redirect_valid keeps priority over the early jump.
- Undefined: no pre-decode. J is fetched sequentially, and a later stage must redirect and flush.

Test Plan:
- Reset: hold rst=0 for 85ns, release; mem[0]=32'h00201820 -> after first edge ifid_inst=32'h00201820, ifid_pc4=4, ifid_valid=1, pc=4, fetch_count=1.
- Sequential fetch of 5 words -> pc steps 4,8,12,16,20; fetch_count=5; ifid_pc4 tracks pc each cycle.
- stall=1 for 2 cycles at pc=8 -> pc stays 8, ifid fields unchanged, fetch_count unchanged; release -> fetch resumes at 8.
- redirect_valid=1, redirect_pc=32'h0000_0033, flush=1 -> pc=32'h30; ifid_valid=0, ifid_inst=0; next edge fetches mem[12].
- stall=1 and flush=1 together -> IF/ID becomes bubble (valid=0); pc holds.
- IF_EARLY_JUMP_EN: mem[14]=32'h08000000 at pc=56 -> ifid_inst=32'h08000000 and pc=0 on same edge. Without the macro -> pc=60.
- Reset asserted mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.
